// File: rtl/ternary_serial_decoder.sv
// Serial balanced-trit to signed binary decoder, MSB trit first, valid/ready on both sides.
// Optional illegal-code flagging is enabled by defining TERNARY_DEC_ERRCHK_EN.
module ternary_serial_decoder #(
  parameter int TRITS = 6,
  parameter int OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_trit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_err
);

  localparam int CNT_W = $clog2(TRITS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TRITS - 1);

  typedef enum logic {S_ACC, S_OUT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic [OUT_W-1:0] w_trit;
  logic [OUT_W-1:0] w_acc_next;
  logic             w_accept;
  logic             w_last;
  logic             w_done;

  assign in_ready  = (r_state == S_ACC);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_accept = in_valid && (r_state == S_ACC);
  assign w_last   = w_accept && (r_cnt == LAST_CNT);
  assign w_done   = (r_state == S_OUT) && out_ready;

  // Illegal code 2'b11 contributes zero in both builds.
  always_comb begin
    w_trit = '0;
    case (in_trit)
      2'b00:   w_trit = '1;
      2'b10:   w_trit = OUT_W'(1);
      default: w_trit = '0;
    endcase
  end

  assign w_acc_next = (r_acc << 1) + r_acc + w_trit;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACC:   if (w_last) w_state_next = S_OUT;
      S_OUT:   if (w_done) w_state_next = S_ACC;
      default: w_state_next = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_done) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_out_data  <= w_acc_next;
        r_out_valid <= 1'b1;
      end
    end
  end

`ifdef TERNARY_DEC_ERRCHK_EN
  logic w_illegal;
  logic r_err_flag;
  logic r_out_err;

  assign w_illegal = (in_trit == 2'b11);
  assign out_err   = r_out_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_flag <= 1'b0;
      r_out_err  <= 1'b0;
    end else if (w_done) begin
      r_err_flag <= 1'b0;
    end else if (w_accept) begin
      r_err_flag <= r_err_flag | w_illegal;
      if (w_last) r_out_err <= r_err_flag | w_illegal;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_serial_decoder.sv
// Scoreboard bench for ternary_serial_decoder (TRITS=6, OUT_W=10).
// Expected words are pushed when a word is issued; a monitor pops on each output handshake.
module tb_ternary_serial_decoder;

  localparam int TRITS = 6;
  localparam int OUT_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_trit;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  logic [OUT_W:0] exp_q[$];

  ternary_serial_decoder #(.TRITS(TRITS), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_trit  (in_trit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each output handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data 0x%0h err %0b with empty scoreboard", out_data, out_err);
      end else begin
        logic [OUT_W:0] e;
        e = exp_q.pop_front();
        check("word_data", 32'(out_data), 32'(e[OUT_W-1:0]));
        check("word_err", 32'(out_err), 32'(e[OUT_W]));
      end
    end
  end

  // Present one trit and hold it until the DUT takes it; returns 1 cycle after the accepting edge.
  task automatic send_trit(input logic [1:0] t, input int gap);
    logic took;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_trit  = t;
    took     = 1'b0;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      #1;
    end
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL trit_accept_timeout: in_ready stayed 0 for 50 cycles");
    end
  endtask

  // word holds six 2-bit codes, MSB trit in bits [11:10].
  task automatic send_word(input logic [11:0] word, input int max_gap,
                           input logic [OUT_W-1:0] exp_data, input logic exp_err,
                           input logic leave_valid);
    exp_q.push_back({exp_err, exp_data});
    for (int i = 0; i < TRITS; i++) begin
      logic [11:0] w;
      w = word;
      send_trit(w[11-2*i -: 2], (max_gap > 0 && i > 0) ? 1 + (i % max_gap) : 0);
    end
    check("latency_out_valid", 32'(out_valid), 32'd1);
    if (!leave_valid) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  localparam logic [11:0] W_228   = 12'b10_01_00_10_10_01;
  localparam logic [11:0] W_P364  = 12'b10_10_10_10_10_10;
  localparam logic [11:0] W_N364  = 12'b00_00_00_00_00_00;
  localparam logic [11:0] W_ILL   = 12'b10_11_00_10_10_01;

  initial begin
    logic exp_ill_err;
`ifdef TERNARY_DEC_ERRCHK_EN
    exp_ill_err = 1'b1;
`else
    exp_ill_err = 1'b0;
`endif
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_trit   = 2'b01;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    @(posedge clk);
    #1;

    // Basic word, back-to-back trits.
    send_word(W_228, 0, 10'h0E4, 1'b0, 1'b0);
    wait_drain();

    // Positive and negative extremes.
    send_word(W_P364, 0, 10'h16C, 1'b0, 1'b0);
    send_word(W_N364, 0, 10'h294, 1'b0, 1'b0);
    wait_drain();

    // Back-pressure: consumer stalls while the source keeps offering a trit.
    out_ready = 1'b0;
    send_word(W_P364, 0, 10'h16C, 1'b0, 1'b1);
    in_trit = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data", 32'(out_data), 32'h16C);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    check("post_hs_data_kept", 32'(out_data), 32'h16C);
    @(posedge clk);
    #1;
    send_word(W_228, 0, 10'h0E4, 1'b0, 1'b0);
    wait_drain();

    // Gaps of 1..3 idle cycles between trits.
    send_word(W_228, 3, 10'h0E4, 1'b0, 1'b0);
    wait_drain();

    // Reset mid-word discards the partial accumulation.
    for (int i = 0; i < 3; i++) begin
      logic [11:0] w;
      w = W_P364;
      send_trit(w[11-2*i -: 2], 0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_out_data", 32'(out_data), 32'd0);
    check("midreset_out_err", 32'(out_err), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_word(W_228, 0, 10'h0E4, 1'b0, 1'b0);
    wait_drain();

    // Illegal code in position 2 counts as zero, so the value matches W_228.
    send_word(W_ILL, 0, 10'h0E4, exp_ill_err, 1'b0);
    send_word(W_228, 0, 10'h0E4, 1'b0, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
